// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
// Slot register fields are stored at MAX_REG_AW bits so one typedef serves any REG_AW up to 8.
package fwd_pkg;

   localparam int MAX_REG_AW      = 8;
   localparam int FWD_RF          = 0;
   localparam int LOAD_READY_SLOT = 2;

   typedef struct packed {
      logic                  valid;
      logic [MAX_REG_AW-1:0] rd;
      logic                  regwr;
      logic                  memrd;
   } slot_t;

   // A producer is only visible if it really writes a non-zero register.
   function automatic logic slotMatch(input slot_t s, input logic [MAX_REG_AW-1:0] r);
      return s.valid && s.regwr && (s.rd == r) && (s.rd != '0);
   endfunction

   function automatic logic slotReady(input slot_t s, input logic [MAX_REG_AW-1:0] r, input int k);
      return slotMatch(s, r) && (!s.memrd || (k >= LOAD_READY_SLOT));
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage side bundle of the forwarding / hazard controller.
interface fwd_hazard_ctrl_if #(
   parameter int  REG_AW = 5,
   parameter int  NFWD   = 2,
   parameter int  CNT_W  = 16,
   localparam int SEL_W  = $clog2(NFWD + 1)
);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_rs_used;
   logic              id_rt_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwr;
   logic              id_memrd;
   logic              id_branch;
   logic              flush;

   logic              stall;
   logic [SEL_W-1:0]  fwd_a;
   logic [SEL_W-1:0]  fwd_b;
   logic [SEL_W-1:0]  bfwd_a;
   logic [SEL_W-1:0]  bfwd_b;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
             id_regwr, id_memrd, id_branch, flush,
      input  stall, fwd_a, fwd_b, bfwd_a, bfwd_b, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
             id_regwr, id_memrd, id_branch, flush,
      output stall, fwd_a, fwd_b, bfwd_a, bfwd_b, stall_cnt
   );

endinterface

// File: rtl/fwd_hazard_ctrl_match.sv
// Priority matcher over slots 1..NFWD: reports the youngest producer of srcReg.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int NFWD  = 2,
   parameter int SEL_W = 2
) (
   input  logic                  enable,
   input  logic [MAX_REG_AW-1:0] srcReg,
   input  slot_t [NFWD:0]        slots,
   output logic                  hit,
   output logic [SEL_W-1:0]      sel,
   output logic                  memrd
);

   // Scan oldest to youngest so the lowest matching slot index wins.
   always_comb begin
      hit   = 1'b0;
      sel   = SEL_W'(FWD_RF);
      memrd = 1'b0;
      for (int k = NFWD; k >= 1; k--) begin
         if (enable && slotMatch(slots[k], srcReg)) begin
            hit   = 1'b1;
            sel   = SEL_W'(k);
            memrd = slots[k].memrd;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: tracks in-flight destinations from EX to the last
// write-back stage and derives forwarding selects, stalls and a saturating stall count.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int  REG_AW = 5,
   parameter int  NFWD   = 2,
   parameter int  CNT_W  = 16,
   localparam int SEL_W  = $clog2(NFWD + 1)
) (
   input logic              clk,
   input logic              rst,
   fwd_hazard_ctrl_if.slave bus
);

   slot_t [NFWD:0]        slotQ;
   logic [MAX_REG_AW-1:0] exRs;
   logic [MAX_REG_AW-1:0] exRt;
   logic                  exRsUsed;
   logic                  exRtUsed;
   logic [CNT_W-1:0]      stallCnt;

   logic [REG_AW-1:0]     rsIn;
   logic [REG_AW-1:0]     rtIn;
   logic [REG_AW-1:0]     rdIn;
   logic [MAX_REG_AW-1:0] idRs;
   logic [MAX_REG_AW-1:0] idRt;
   slot_t                 idSlot;

   logic                  issue;
   logic                  stallInt;
   logic                  hazA;
   logic                  hazB;
   logic                  branchEn;

   logic [SEL_W-1:0]      fwdA;
   logic [SEL_W-1:0]      fwdB;
   logic [SEL_W-1:0]      bSelA;
   logic [SEL_W-1:0]      bSelB;
   logic                  bHitA;
   logic                  bHitB;
   logic                  bMemA;
   logic                  bMemB;
   logic                  unusedHitA;
   logic                  unusedHitB;
   logic                  unusedMemA;
   logic                  unusedMemB;

   assign rsIn     = bus.id_rs;
   assign rtIn     = bus.id_rt;
   assign rdIn     = bus.id_rd;
   assign idRs     = MAX_REG_AW'(rsIn);
   assign idRt     = MAX_REG_AW'(rtIn);
   assign idSlot   = '{valid: 1'b1, rd: MAX_REG_AW'(rdIn),
                       regwr: bus.id_regwr, memrd: bus.id_memrd};
   assign branchEn = bus.id_branch && bus.id_valid;

   // Downstream stages never stall, so the slot pipeline shifts every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slotQ    <= '0;
         exRs     <= '0;
         exRt     <= '0;
         exRsUsed <= 1'b0;
         exRtUsed <= 1'b0;
      end else begin
         for (int k = NFWD; k >= 1; k--) begin
            slotQ[k] <= slotQ[k-1];
         end
         slotQ[0] <= issue ? idSlot : slot_t'('0);
         exRs     <= idRs;
         exRt     <= idRt;
         exRsUsed <= issue && bus.id_rs_used;
         exRtUsed <= issue && bus.id_rt_used;
      end
   end

   fwd_match #(.NFWD(NFWD), .SEL_W(SEL_W)) uMatchExA (
      .enable(exRsUsed), .srcReg(exRs), .slots(slotQ),
      .hit(unusedHitA), .sel(fwdA), .memrd(unusedMemA)
   );

   fwd_match #(.NFWD(NFWD), .SEL_W(SEL_W)) uMatchExB (
      .enable(exRtUsed), .srcReg(exRt), .slots(slotQ),
      .hit(unusedHitB), .sel(fwdB), .memrd(unusedMemB)
   );

   fwd_match #(.NFWD(NFWD), .SEL_W(SEL_W)) uMatchBrA (
      .enable(branchEn), .srcReg(idRs), .slots(slotQ),
      .hit(bHitA), .sel(bSelA), .memrd(bMemA)
   );

   fwd_match #(.NFWD(NFWD), .SEL_W(SEL_W)) uMatchBrB (
      .enable(branchEn), .srcReg(idRt), .slots(slotQ),
      .hit(bHitB), .sel(bSelB), .memrd(bMemB)
   );

   // A branch compares in ID, so it must wait for any EX producer and for a load still in MEM.
   always_comb begin
      hazA = 1'b0;
      hazB = 1'b0;
      if (bus.id_rs_used) begin
         hazA = (slotMatch(slotQ[0], idRs) && !slotReady(slotQ[0], idRs, 0))
             || (bus.id_branch && slotMatch(slotQ[0], idRs))
             || (bus.id_branch && bHitA && (bSelA == SEL_W'(1)) && bMemA);
      end
      if (bus.id_rt_used) begin
         hazB = (slotMatch(slotQ[0], idRt) && !slotReady(slotQ[0], idRt, 0))
             || (bus.id_branch && slotMatch(slotQ[0], idRt))
             || (bus.id_branch && bHitB && (bSelB == SEL_W'(1)) && bMemB);
      end
   end

   assign stallInt = bus.id_valid && !bus.flush && (hazA || hazB);
   assign issue    = bus.id_valid && !stallInt && !bus.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= '0;
      end else if (stallInt && (stallCnt != '1)) begin
         stallCnt <= stallCnt + CNT_W'(1);
      end
   end

   assign bus.stall     = stallInt;
   assign bus.fwd_a     = fwdA;
   assign bus.fwd_b     = fwdB;
   assign bus.bfwd_a    = bSelA;
   assign bus.bfwd_b    = bSelB;
   assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with hand-computed expectations (NFWD = 2, CNT_W = 4).
module tb_fwd_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl_if #(.REG_AW(5), .NFWD(2), .CNT_W(4)) bus ();

   fwd_hazard_ctrl #(.REG_AW(5), .NFWD(2), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input int rs, input int rt,
                                input logic rsUsed, input logic rtUsed, input int rd,
                                input logic regwr, input logic memrd, input logic branch,
                                input logic flushIn);
      bus.id_valid   = valid;
      bus.id_rs      = 5'(rs);
      bus.id_rt      = 5'(rt);
      bus.id_rs_used = rsUsed;
      bus.id_rt_used = rtUsed;
      bus.id_rd      = 5'(rd);
      bus.id_regwr   = regwr;
      bus.id_memrd   = memrd;
      bus.id_branch  = branch;
      bus.flush      = flushIn;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      idle();
      repeat (3) tick();
   endtask

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input int expStall, input int expFa,
                              input int expFb, input int expBa, input int expBb,
                              input int expCnt);
      checkVal({tag, ".stall"},  32'(bus.stall),     32'(expStall));
      checkVal({tag, ".fwdA"},   32'(bus.fwd_a),     32'(expFa));
      checkVal({tag, ".fwdB"},   32'(bus.fwd_b),     32'(expFb));
      checkVal({tag, ".bfwdA"},  32'(bus.bfwd_a),    32'(expBa));
      checkVal({tag, ".bfwdB"},  32'(bus.bfwd_b),    32'(expBb));
      checkVal({tag, ".cnt"},    32'(bus.stall_cnt), 32'(expCnt));
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("reset", 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("postReset", 0, 0, 0, 0, 0, 0);

      // add r5 ; sub r6,r5,r7
      drain();
      applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
      checkVal("addIssue.stall", 32'(bus.stall), 0);
      tick();
      applyStimulus(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);
      checkVal("subInId.stall", 32'(bus.stall), 0);
      tick();
      idle();
      checkOutput("subInEx", 0, 1, 0, 0, 0, 0);

      // lw r4 ; add r8,r4,r4
      drain();
      applyStimulus(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 4, 4, 1, 1, 8, 1, 0, 0, 0);
      checkOutput("loadUse", 1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("loadUseBubble", 0, 0, 0, 0, 0, 1);
      tick();
      idle();
      checkOutput("loadUseFwd", 0, 2, 2, 0, 0, 1);

      // lw r9 ; beq r9,r0
      drain();
      applyStimulus(1, 1, 0, 1, 0, 9, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 9, 0, 1, 1, 0, 0, 0, 1, 0);
      checkOutput("ldBr1", 1, 0, 0, 0, 0, 1);
      tick();
      checkOutput("ldBr2", 1, 0, 0, 1, 0, 2);
      tick();
      checkOutput("ldBrGo", 0, 0, 0, 2, 0, 3);
      tick();

      // add r10 ; beq r10,r11
      drain();
      applyStimulus(1, 1, 0, 1, 0, 10, 1, 0, 0, 0);
      tick();
      applyStimulus(1, 10, 11, 1, 1, 0, 0, 0, 1, 0);
      checkOutput("aluBr1", 1, 0, 0, 0, 0, 3);
      tick();
      checkOutput("aluBrGo", 0, 0, 0, 1, 0, 4);
      tick();

      // lw r2 ; add r2 ; use r2 (rt=r2 but unused)
      drain();
      applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 1, 3, 1, 1, 2, 1, 0, 0, 0);
      checkVal("addR2.stall", 32'(bus.stall), 0);
      tick();
      applyStimulus(1, 2, 2, 1, 0, 3, 1, 0, 0, 0);
      checkVal("useR2.stall", 32'(bus.stall), 0);
      tick();
      idle();
      checkOutput("nearest", 0, 1, 0, 0, 0, 4);

      // rd = 0 producers never forward or stall
      drain();
      applyStimulus(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 1, 0);
      checkOutput("r0Br", 0, 0, 0, 0, 0, 4);
      tick();
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 1, 0);
      checkOutput("r0Ex", 0, 0, 0, 0, 0, 4);
      tick();

      // load-use hazard squashed by flush
      drain();
      applyStimulus(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 4, 4, 1, 1, 8, 1, 0, 0, 1);
      checkOutput("flushHaz", 0, 0, 0, 0, 0, 4);
      tick();
      applyStimulus(1, 8, 0, 1, 0, 0, 0, 0, 1, 0);
      checkOutput("afterFlush", 0, 0, 0, 0, 0, 4);
      tick();

      // 19 single-cycle load-use stalls drive the 4-bit counter into saturation
      drain();
      for (int i = 0; i < 19; i++) begin
         applyStimulus(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
         tick();
         applyStimulus(1, 4, 0, 1, 0, 8, 1, 0, 0, 0);
         tick();
         tick();
         if (i == 9) checkVal("cntBeforeSat", 32'(bus.stall_cnt), 14);
      end
      idle();
      checkVal("cntSaturated", 32'(bus.stall_cnt), 15);

      // asynchronous reset in the middle of a stall
      applyStimulus(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 4, 0, 1, 0, 8, 1, 0, 0, 0);
      checkVal("preRst.stall", 32'(bus.stall), 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncRst", 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("afterAsyncRst", 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the in-order pipeline. It sits beside the ID stage and tracks the destination tag of every in-flight instruction from EX through the last write-back stage in an internal slot pipeline. It drives operand-forwarding selects for the EX stage and for the ID-stage branch comparator. It also generates load-use and branch-dependency stalls and handles flush squashing, and keeps a saturating stall counter.

## Interface
- REG_AW, 5, register address width
- NFWD, 2, number of forwarding source stages after EX (slot 1 = MEM … slot NFWD = WB)
- CNT_W, 16, stall counter width
- SEL_W, $clog2(NFWD+1), forward select width (derived, not overridden)

- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_rs_used, id_rt_used  in  1  source actually read
- id_rd  in  REG_AW  ID destination
- id_regwr  in  1  ID instruction writes a register
- id_memrd  in  1  ID instruction is a load
- id_branch  in  1  ID instruction is a branch compared in ID
- flush  in  1  squash the ID instruction this cycle
- stall  out  1  hold PC and IF/ID; ID/EX receives a bubble
- fwd_a, fwd_b  out  SEL_W  EX operand select: 0 = regfile, k = slot k result
- bfwd_a, bfwd_b  out  SEL_W  ID branch operand select, same encoding
- stall_cnt  out  CNT_W  total stall cycles, saturating

## Operation
- Slot k, k = 0..NFWD, holds {valid, rd, regwr, memrd}; slot 0 = EX. EX also registers ex_rs, ex_rt, ex_rs_used, ex_rt_used.
- Every cycle all slots shift: slot k+1 ← slot k, and the last slot's contents are dropped. Slot 0 ← ID fields when id_valid && !stall && !flush, else a bubble (valid = 0). Downstream stages never stall.
- A match at slot k for register r requires: valid, regwr, rd == r, rd != 0.
- Result-ready at slot k: match && (!memrd || k ≥ 2).
- fwd_a: the lowest k in 1..NFWD that matches ex_rs, and only when ex_rs_used; otherwise 0. fwd_b is the same for ex_rt. The youngest producer wins.
- bfwd_a/b: the lowest k in 1..NFWD that matches id_rs/id_rt, and only when id_branch && id_valid; otherwise 0.
- Hazard on a used source r of a valid ID instruction:
  - load-use: slot 0 matches r and has memrd
  - branch-on-EX: id_branch and slot 0 matches r
  - branch-on-load-in-MEM: id_branch and the nearest matching slot is 1 and has memrd
- stall = id_valid && !flush && any hazard. flush overrides stall.
- stall_cnt increments on each stall cycle and holds at all-ones.

## Timing
- All outputs are combinational from slot registers and the current ID inputs. There is no output register.
- Reset: all slots invalid and ex_* cleared. Therefore fwd_a = fwd_b = bfwd_a = bfwd_b = 0, stall = 0 with id_valid low, and stall_cnt = 0.
- Load → dependent ALU op: 1 stall cycle, then fwd = 2 (WB).
- ALU → dependent ALU op: no stall, fwd = 1.
- ALU → dependent branch: 1 stall, then bfwd = 1.
- Load → dependent branch: 2 stalls, then bfwd = 2.
- Reset asserted mid-operation clears slots immediately, whatever the clock; stalls in progress are abandoned.
- flush and a hazard in the same cycle: stall = 0, bubble into slot 0, no stall_cnt increment.
- Matches on r = 0 never forward and never stall.

## Structure
- Package fwd_pkg holds:
  - slot_t typedef {valid, rd, regwr, memrd}
  - FWD_RF = 0 select constant
  - the ready-stage constant LOAD_READY_SLOT = 2
- Sub-module fwd_match: a priority matcher over slots 1..NFWD that returns {hit, sel, memrd}. It is instantiated four times (EX a/b, branch a/b).
- The top module holds the slot shift register, the hazard logic and the counter.

## Test plan
- Reset with id_valid = 1, id_rs = 3: all selects = 0, stall = 0, stall_cnt = 0; deassert reset and check the state holds.
- add r5 then sub r6,r5,r7: EX cycle of sub gives fwd_a = 1, fwd_b = 0, stall never asserted.
- lw r4 then add r8,r4,r4: exactly one stall cycle, slot 0 bubble; next cycle fwd_a = fwd_b = 2; stall_cnt = 1.
- lw r9 then beq r9,r0: stall 2 cycles, then bfwd_a = 2, bfwd_b = 0; stall_cnt += 2.
- add r2 in MEM and lw r2 in WB both matching the EX rs: fwd_a = 1 (nearest wins). With rd = 0 producers: all selects = 0.
- Load-use hazard with flush = 1 in the same cycle: stall = 0, slot 0 invalid next cycle. Then force 2^CNT_W+3 stalls (CNT_W = 4 for this test): stall_cnt saturates at 15.
